// File: rtl/dac_spi_driver_if.sv
// dac_spi_driver_if: sample bus in, Pmod DAC serial lines and status out.
// Master drives samples/enable, slave is the serialiser.
interface dac_spi_driver_if;
  logic        enable;
  logic [11:0] sample_a;
  logic [11:0] sample_b;
  logic [1:0]  pd_mode;
  logic        dac_sclk;
  logic        dac_sync_n;
  logic        dac_din_a;
  logic        dac_din_b;
  logic        sample_tick;
  logic        busy;
  logic        frame_done;
  logic        overrun;

  modport master (
    output enable, sample_a, sample_b, pd_mode,
    input  dac_sclk, dac_sync_n, dac_din_a, dac_din_b,
    input  sample_tick, busy, frame_done, overrun
  );

  modport slave (
    input  enable, sample_a, sample_b, pd_mode,
    output dac_sclk, dac_sync_n, dac_din_a, dac_din_b,
    output sample_tick, busy, frame_done, overrun
  );
endinterface

// File: rtl/dac_spi_driver.sv
// dac_spi_driver: periodic dual-channel 16-bit frame serialiser
// for a DAC121S101-style Pmod DAC sharing SCLK and SYNC_n.
module dac_spi_driver #(
  parameter int CLK_DIV    = 2,
  parameter int UPDATE_DIV = 100
) (
  input  logic             clk,
  input  logic             rst_n,
  dac_spi_driver_if.slave  bus
);
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int QW = $clog2(2 * CLK_DIV + 1);
  localparam int UW = $clog2(UPDATE_DIV + 1);
  localparam logic [HW-1:0] HC_TOP = HW'(CLK_DIV - 1);
  localparam logic [QW-1:0] QC_TOP = QW'(2 * CLK_DIV - 1);
  localparam logic [UW-1:0] UC_TOP = UW'(UPDATE_DIV - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, QUIET} state_t;

  state_t        state_q, state_d;
  logic [UW-1:0] uc_q, uc_d;
  logic [HW-1:0] hc_q, hc_d;
  logic [QW-1:0] qc_q, qc_d;
  logic [4:0]    bc_q, bc_d;
  logic [15:0]   sha_q, sha_d;
  logic [15:0]   shb_q, shb_d;
  logic          sclk_q, sclk_d;
  logic          sync_q, sync_d;
  logic          dina_q, dina_d;
  logic          dinb_q, dinb_d;
  logic          stick_q, stick_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          ovr_q, ovr_d;

  logic          tick;
  logic [15:0]   word_a;
  logic [15:0]   word_b;

  assign tick   = bus.enable && (uc_q == UC_TOP);
  assign word_a = {2'b00, bus.pd_mode, bus.sample_a};
  assign word_b = {2'b00, bus.pd_mode, bus.sample_b};

  // Next-state: update timer, overrun flag and frame sequencer
  always_comb begin
    state_d = state_q;
    uc_d    = uc_q;
    hc_d    = hc_q;
    qc_d    = qc_q;
    bc_d    = bc_q;
    sha_d   = sha_q;
    shb_d   = shb_q;
    sclk_d  = sclk_q;
    sync_d  = sync_q;
    dina_d  = dina_q;
    dinb_d  = dinb_q;
    stick_d = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovr_d   = ovr_q;

    if (!bus.enable || tick) uc_d = '0;
    else                     uc_d = uc_q + 1'b1;

    if (!bus.enable)                   ovr_d = 1'b0;
    else if (tick && state_q != IDLE)  ovr_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (tick) begin
          sha_d   = word_a;
          shb_d   = word_b;
          dina_d  = word_a[15];
          dinb_d  = word_b[15];
          sync_d  = 1'b0;
          stick_d = 1'b1;
          busy_d  = 1'b1;
          hc_d    = '0;
          bc_d    = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (hc_q == HC_TOP) begin
          hc_d   = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            bc_d = bc_q + 1'b1;
          end else if (bc_q == 5'd16) begin
            sync_d  = 1'b1;
            dina_d  = 1'b0;
            dinb_d  = 1'b0;
            qc_d    = '0;
            state_d = QUIET;
          end else begin
            sha_d  = {sha_q[14:0], 1'b0};
            shb_d  = {shb_q[14:0], 1'b0};
            dina_d = sha_q[14];
            dinb_d = shb_q[14];
          end
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      QUIET: begin
        if (qc_q == QC_TOP) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          qc_d = qc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      uc_q    <= '0;
      hc_q    <= '0;
      qc_q    <= '0;
      bc_q    <= '0;
      sha_q   <= '0;
      shb_q   <= '0;
      sclk_q  <= 1'b1;
      sync_q  <= 1'b1;
      dina_q  <= 1'b0;
      dinb_q  <= 1'b0;
      stick_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      uc_q    <= uc_d;
      hc_q    <= hc_d;
      qc_q    <= qc_d;
      bc_q    <= bc_d;
      sha_q   <= sha_d;
      shb_q   <= shb_d;
      sclk_q  <= sclk_d;
      sync_q  <= sync_d;
      dina_q  <= dina_d;
      dinb_q  <= dinb_d;
      stick_q <= stick_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.dac_sclk    = sclk_q;
  assign bus.dac_sync_n  = sync_q;
  assign bus.dac_din_a   = dina_q;
  assign bus.dac_din_b   = dinb_q;
  assign bus.sample_tick = stick_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = done_q;
  assign bus.overrun     = ovr_q;
endmodule

// File: tb/tb_dac_spi_driver.sv
// tb_dac_spi_driver: directed checks of frame timing, data,
// reset, enable handling and overrun.
module tb_dac_spi_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dac_spi_driver_if bus ();
  dac_spi_driver_if bus2 ();

  dac_spi_driver u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  dac_spi_driver #(
    .CLK_DIV    (2),
    .UPDATE_DIV (40)
  ) u_ovr (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2.slave)
  );

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit scr    = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_tick(output int n, output int npre,
                           output logic [11:0] cap);
    bit got;
    n = 0;
    npre = 0;
    got = 1'b0;
    cap = '0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      if (bus.sample_tick) begin
        got = 1'b1;
        cap = bus.sample_a;
      end else begin
        if (!bus.dac_sync_n) npre++;
        if (scr) bus.sample_a = 12'($urandom);
      end
    end
    chk("tick_seen", 32'(got), 32'd1);
  endtask

  task automatic capture(input int drop_at,
                         output logic [15:0] wa,
                         output logic [15:0] wb,
                         output int nfall, output int nsync,
                         output int nbusy, output int ndone);
    logic prev;
    int n;
    wa = '0;
    wb = '0;
    nfall = 0;
    nsync = 0;
    nbusy = 0;
    ndone = 0;
    prev = 1'b1;
    n = 0;
    while (ndone == 0 && n < 300) begin
      if (!bus.dac_sync_n) nsync++;
      if (bus.busy) nbusy++;
      if (prev && !bus.dac_sclk) begin
        nfall++;
        wa = {wa[14:0], bus.dac_din_a};
        wb = {wb[14:0], bus.dac_din_b};
      end
      prev = bus.dac_sclk;
      if (scr) bus.sample_a = 12'($urandom);
      if (n == drop_at) bus.enable = 1'b0;
      @(negedge clk);
      n++;
      if (bus.frame_done) ndone++;
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_sclk"}, 32'(bus.dac_sclk), 32'd1);
    chk({tag, "_sync"}, 32'(bus.dac_sync_n), 32'd1);
    chk({tag, "_dina"}, 32'(bus.dac_din_a), 32'd0);
    chk({tag, "_dinb"}, 32'(bus.dac_din_b), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_tick"}, 32'(bus.sample_tick), 32'd0);
  endtask

  initial begin
    int n, npre, t0, nt, ns;
    int nfall, nsync, nbusy, ndone;
    logic [11:0] cap;
    logic [15:0] wa, wb;

    bus.enable   = 1'b1;
    bus.sample_a = 12'hA5C;
    bus.sample_b = 12'h3F0;
    bus.pd_mode  = 2'b00;
    bus2.enable   = 1'b0;
    bus2.sample_a = 12'h000;
    bus2.sample_b = 12'h000;
    bus2.pd_mode  = 2'b00;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("rst");
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_ovr", 32'(bus.overrun), 32'd0);
    rst_n = 1'b1;

    wait_tick(n, npre, cap);
    chk("first_tick_lat", 32'(n - 1), 32'd99);
    t0 = cyc;
    capture(-1, wa, wb, nfall, nsync, nbusy, ndone);
    chk("f1_word_a", 32'(wa), 32'h0A5C);
    chk("f1_word_b", 32'(wb), 32'h03F0);
    chk("f1_falls", 32'(nfall), 32'd16);
    chk("f1_sync_low", 32'(nsync), 32'd64);
    chk("f1_busy", 32'(nbusy), 32'd68);
    chk("f1_done", 32'(ndone), 32'd1);
    @(negedge clk);
    chk("f1_done_single", 32'(bus.frame_done), 32'd0);
    chk("f1_ovr", 32'(bus.overrun), 32'd0);

    wait_tick(n, npre, cap);
    chk("frame_period", 32'(cyc - t0), 32'd100);
    bus.pd_mode = 2'b11;
    scr = 1'b1;
    capture(-1, wa, wb, nfall, nsync, nbusy, ndone);
    chk("f2_hold_word_a", 32'(wa), 32'h0A5C);
    chk("f2_hold_word_b", 32'(wb), 32'h03F0);

    wait_tick(n, npre, cap);
    capture(-1, wa, wb, nfall, nsync, nbusy, ndone);
    chk("f3_word_a", 32'(wa), 32'({4'h3, cap}));
    chk("f3_pd_nibble", 32'(wa[15:12]), 32'h3);
    chk("f3_word_b", 32'(wb), 32'h33F0);
    chk("f3_falls", 32'(nfall), 32'd16);

    scr = 1'b0;
    bus.sample_a = 12'hA5C;
    bus.pd_mode  = 2'b00;
    wait_tick(n, npre, cap);
    repeat (20) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_idle("midrst");
    rst_n = 1'b1;
    wait_tick(n, npre, cap);
    chk("midrst_no_partial", 32'(npre), 32'd0);
    chk("midrst_tick_lat", 32'(n - 1), 32'd99);

    capture(10, wa, wb, nfall, nsync, nbusy, ndone);
    chk("drop_word_a", 32'(wa), 32'h0A5C);
    chk("drop_word_b", 32'(wb), 32'h03F0);
    chk("drop_falls", 32'(nfall), 32'd16);
    chk("drop_sync_low", 32'(nsync), 32'd64);
    chk("drop_done", 32'(ndone), 32'd1);
    nt = 0;
    ns = 0;
    repeat (250) begin
      @(negedge clk);
      if (bus.sample_tick) nt++;
      if (!bus.dac_sync_n) ns++;
    end
    chk("drop_no_tick", 32'(nt), 32'd0);
    chk("drop_no_sync", 32'(ns), 32'd0);
    bus.enable = 1'b1;
    wait_tick(n, npre, cap);
    chk("reen_tick_lat", 32'(n - 1), 32'd99);
    chk("reen_ovr", 32'(bus.overrun), 32'd0);

    chk("ovr_init", 32'(bus2.overrun), 32'd0);
    bus2.enable = 1'b1;
    nt = 0;
    repeat (170) begin
      @(negedge clk);
      if (bus2.sample_tick) nt++;
    end
    chk("ovr_ticks_kept", 32'(nt), 32'd2);
    chk("ovr_set", 32'(bus2.overrun), 32'd1);
    bus2.enable = 1'b0;
    @(negedge clk);
    chk("ovr_clear", 32'(bus2.overrun), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
